sync_pipe_controller: RTL and testbench

- Clocked, parametrised instruction-sequencing controller for the RISC-V core datapath.
- Issues req pulses per stage: fetch, fork of decode and GPR-read, join, then opcode dispatch to the branch, load/store or ALU path, then merge into GPR write-back.
- Successor to the self-timed req/ack controller, adding:
  - programmable per-class latencies
  - back-pressured memory handshake
  - illegal-opcode trap path
  - a retire counter

---
 rtl/sync_pipe_controller.sv | 149 ++++++++++++++
 tb/tb_sync_pipe_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pipe_controller.sv
// Clocked instruction-sequencing controller: fetch, forked decode/GPR-read join,
// opcode dispatch to branch, memory or ALU path, write-back and retire.
module sync_pipe_controller #(
    parameter int OPW     = 7,
    parameter int ALU_LAT = 1,
    parameter int BR_LAT  = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPW-1:0]   opcode,
    input  logic             fetch_ack,
    input  logic             dec_ack,
    input  logic             gpr_ack,
    input  logic             mem_ack,
    output logic             req1,
    output logic             req2_1,
    output logic             req2_2,
    output logic             req3,
    output logic             req4,
    output logic             req_br,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             busy
);

    localparam logic [OPW-1:0] OP_BRANCH = OPW'(7'b1100011);
    localparam logic [OPW-1:0] OP_JAL    = OPW'(7'b1101111);
    localparam logic [OPW-1:0] OP_JALR   = OPW'(7'b1100111);
    localparam logic [OPW-1:0] OP_LOAD   = OPW'(7'b0000011);
    localparam logic [OPW-1:0] OP_STORE  = OPW'(7'b0100011);
    localparam logic [OPW-1:0] OP_OP     = OPW'(7'b0110011);
    localparam logic [OPW-1:0] OP_IMM    = OPW'(7'b0010011);
    localparam logic [OPW-1:0] OP_LUI    = OPW'(7'b0110111);
    localparam logic [OPW-1:0] OP_AUIPC  = OPW'(7'b0010111);

    localparam logic [3:0] ALU_LOAD = 4'(ALU_LAT - 1);
    localparam logic [3:0] BR_LOAD  = 4'(BR_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, DISPATCH, EXEC, BRX, MEM, WB, RET, TRAP
    } state_t;

    state_t     state, state_n;
    logic       rst_sync;
    logic       dec_done, dec_done_n;
    logic       gpr_done, gpr_done_n;
    logic [3:0] lat_cnt, lat_n;
    logic       wb_pend, wb_n;

    always_comb begin
        state_n    = state;
        dec_done_n = dec_done;
        gpr_done_n = gpr_done;
        lat_n      = lat_cnt;
        wb_n       = wb_pend;
        unique case (state)
            IDLE:  if (run) state_n = FETCH;
            FETCH: if (fetch_ack) state_n = DECODE;
            DECODE: begin
                if ((dec_done || dec_ack) && (gpr_done || gpr_ack)) begin
                    state_n    = DISPATCH;
                    dec_done_n = 1'b0;
                    gpr_done_n = 1'b0;
                end else begin
                    dec_done_n = dec_done || dec_ack;
                    gpr_done_n = gpr_done || gpr_ack;
                end
            end
            DISPATCH: begin
                // wb_pend records whether the selected path ends in write-back
                unique case (opcode)
                    OP_BRANCH: begin
                        state_n = BRX;
                        lat_n   = BR_LOAD;
                        wb_n    = 1'b0;
                    end
                    OP_JAL, OP_JALR: begin
                        state_n = BRX;
                        lat_n   = BR_LOAD;
                        wb_n    = 1'b1;
                    end
                    OP_LOAD: begin
                        state_n = MEM;
                        wb_n    = 1'b1;
                    end
                    OP_STORE: begin
                        state_n = MEM;
                        wb_n    = 1'b0;
                    end
                    OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
                        state_n = EXEC;
                        lat_n   = ALU_LOAD;
                        wb_n    = 1'b1;
                    end
                    default: state_n = TRAP;
                endcase
            end
            EXEC: begin
                if (lat_cnt == '0) state_n = WB;
                else lat_n = lat_cnt - 4'd1;
            end
            BRX: begin
                if (lat_cnt == '0) state_n = wb_pend ? WB : RET;
                else lat_n = lat_cnt - 4'd1;
            end
            MEM:       if (mem_ack) state_n = wb_pend ? WB : RET;
            WB:        state_n = RET;
            RET, TRAP: state_n = run ? FETCH : IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // rst_sync holds the FSM for one edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync   <= 1'b0;
            state      <= IDLE;
            dec_done   <= 1'b0;
            gpr_done   <= 1'b0;
            lat_cnt    <= '0;
            wb_pend    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            rst_sync <= 1'b1;
            if (rst_sync) begin
                state    <= state_n;
                dec_done <= dec_done_n;
                gpr_done <= gpr_done_n;
                lat_cnt  <= lat_n;
                wb_pend  <= wb_n;
                if (state == RET) retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign req1    = (state == FETCH);
    assign req2_1  = (state == DECODE) && !dec_done;
    assign req2_2  = (state == DECODE) && !gpr_done;
    assign req3    = (state == MEM);
    assign req4    = (state == WB);
    assign req_br  = (state == BRX);
    assign illegal = (state == TRAP);
    assign retire  = (state == RET);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_sync_pipe_controller.sv
// Self-checking bench: per-instruction cycle timelines built from the stage rules,
// driven open-loop with random noise on every input the current stage ignores.
module tb_sync_pipe_controller;

    localparam int ALU_LAT = 1;
    localparam int BR_LAT  = 3;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic [6:0]       opcode = '0;
    logic             fetch_ack = 1'b0, dec_ack = 1'b0, gpr_ack = 1'b0, mem_ack = 1'b0;
    logic             req1, req2_1, req2_2, req3, req4, req_br, illegal, retire, busy;
    logic [CNT_W-1:0] retire_cnt;

    sync_pipe_controller #(
        .OPW(7), .ALU_LAT(ALU_LAT), .BR_LAT(BR_LAT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .fetch_ack(fetch_ack), .dec_ack(dec_ack), .gpr_ack(gpr_ack), .mem_ack(mem_ack),
        .req1(req1), .req2_1(req2_1), .req2_2(req2_2), .req3(req3), .req4(req4),
        .req_br(req_br), .illegal(illegal), .retire(retire),
        .retire_cnt(retire_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run;
        logic [6:0] op;
        logic       fa, da, ga, ma;
    } stim_t;

    typedef struct packed {
        logic req1, req2_1, req2_2, req3, req4, req_br, illegal, retire, busy;
    } outv_t;

    localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;

    stim_t            sq[$];
    outv_t            eq[$];
    logic [CNT_W-1:0] cq[$];
    logic [CNT_W-1:0] mcnt;
    int               errors = 0;
    int               checks = 0;
    string            tname;

    function automatic stim_t noise();
        stim_t s;
        s.run = 1'($urandom);
        s.op  = 7'($urandom);
        s.fa  = 1'($urandom);
        s.da  = 1'($urandom);
        s.ga  = 1'($urandom);
        s.ma  = 1'($urandom);
        return s;
    endfunction

    function automatic outv_t outs_now();
        return {req1, req2_1, req2_2, req3, req4, req_br, illegal, retire, busy};
    endfunction

    task automatic push(input stim_t s, input outv_t e);
        sq.push_back(s);
        eq.push_back(e);
        cq.push_back(mcnt);
    endtask

    task automatic push_idle(input logic r);
        stim_t s;
        s = noise();
        s.run = r;
        push(s, '0);
    endtask

    // Expected timeline of one instruction, given the cycle (within each
    // waiting stage) on which the bench raises the matching ack.
    task automatic add_instr(input logic [6:0] op, input int f, input int d,
                             input int g, input int m, input logic run_after);
        stim_t s;
        outv_t e;
        int    dg;
        logic  wb;
        logic  ill;
        wb  = 1'b0;
        ill = 1'b0;
        for (int j = 0; j <= f; j++) begin
            s = noise(); s.fa = (j == f);
            e = '0; e.req1 = 1'b1; e.busy = 1'b1;
            push(s, e);
        end
        dg = (d > g) ? d : g;
        for (int j = 0; j <= dg; j++) begin
            s = noise();
            if (j <= d) s.da = (j == d);
            if (j <= g) s.ga = (j == g);
            e = '0; e.req2_1 = (j <= d); e.req2_2 = (j <= g); e.busy = 1'b1;
            push(s, e);
        end
        s = noise(); s.op = op;
        e = '0; e.busy = 1'b1;
        push(s, e);
        case (op)
            OPR, OPI, LUI, AUIPC: begin
                for (int j = 0; j < ALU_LAT; j++) begin
                    e = '0; e.busy = 1'b1;
                    push(noise(), e);
                end
                wb = 1'b1;
            end
            BEQ, JAL, JALR: begin
                for (int j = 0; j < BR_LAT; j++) begin
                    e = '0; e.req_br = 1'b1; e.busy = 1'b1;
                    push(noise(), e);
                end
                wb = (op != BEQ);
            end
            LD, ST: begin
                for (int j = 0; j <= m; j++) begin
                    s = noise(); s.ma = (j == m);
                    e = '0; e.req3 = 1'b1; e.busy = 1'b1;
                    push(s, e);
                end
                wb = (op == LD);
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            s = noise(); s.run = run_after;
            e = '0; e.illegal = 1'b1; e.busy = 1'b1;
            push(s, e);
        end else begin
            if (wb) begin
                e = '0; e.req4 = 1'b1; e.busy = 1'b1;
                push(noise(), e);
            end
            s = noise(); s.run = run_after;
            e = '0; e.retire = 1'b1; e.busy = 1'b1;
            push(s, e);
            mcnt = mcnt + 1'b1;
        end
    endtask

    // Runs the first n queued cycles (all if n < 0), then empties the queues.
    task automatic run_seg(input int n);
        outv_t got;
        int    lim;
        lim = (n < 0) ? sq.size() : n;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            got = outs_now();
            checks++;
            if (got !== eq[i]) begin
                errors++;
                $display("FAIL %s outputs cyc=%0d got=%b want=%b", tname, i, got, eq[i]);
            end
            checks++;
            if (retire_cnt !== cq[i]) begin
                errors++;
                $display("FAIL %s retire_cnt cyc=%0d got=%0d want=%0d", tname, i, retire_cnt, cq[i]);
            end
            run       = sq[i].run;
            opcode    = sq[i].op;
            fetch_ack = sq[i].fa;
            dec_ack   = sq[i].da;
            gpr_ack   = sq[i].ga;
            mem_ack   = sq[i].ma;
        end
        sq.delete();
        eq.delete();
        cq.delete();
    endtask

    task automatic hold_reset_check();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs_now() !== outv_t'('0) || retire_cnt !== '0) begin
                errors++;
                $display("FAIL %s in_reset got=%b cnt=%0d want=0 cnt=0", tname, outs_now(), retire_cnt);
            end
            run = 1'b1; fetch_ack = 1'($urandom); dec_ack = 1'($urandom);
            gpr_ack = 1'($urandom); mem_ack = 1'($urandom);
        end
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        mcnt  = '0;
    endtask

    task automatic test_reset();
        tname = "reset";
        #1 reset = 1'b0;
        hold_reset_check();
    endtask

    task automatic test_alu();
        tname = "alu";
        push_idle(1'b1);
        add_instr(OPR, 0, 0, 0, 0, 1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_join();
        tname = "join";
        push_idle(1'b1);
        add_instr(OPR, 0, 3, 1, 0, 1'b1);
        add_instr(OPI, 1, 2, 2, 0, 1'b1);
        add_instr(LUI, 0, 0, 4, 0, 1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_mem();
        tname = "mem";
        push_idle(1'b1);
        add_instr(LD, 0, 0, 0, 7, 1'b1);
        add_instr(ST, 0, 0, 0, 7, 1'b1);
        add_instr(ST, 2, 1, 0, 0, 1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_branch();
        tname = "branch";
        push_idle(1'b1);
        add_instr(BEQ, 0, 0, 0, 0, 1'b1);
        add_instr(JAL, 0, 0, 0, 0, 1'b1);
        add_instr(JALR, 1, 1, 1, 0, 1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_illegal_stop();
        tname = "illegal_stop";
        push_idle(1'b1);
        add_instr(7'b1111111, 0, 0, 0, 0, 1'b1);
        add_instr(7'b0000000, 0, 1, 0, 0, 1'b1);
        add_instr(LD, 0, 0, 0, 4, 1'b0);
        push_idle(1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] alu_ops [4];
        alu_ops = '{OPR, OPI, LUI, AUIPC};
        tname = "back_to_back";
        push_idle(1'b1);
        for (int i = 0; i < 16; i++)
            add_instr(alu_ops[i % 4], 0, 0, 0, 0, i != 15);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [6:0] op;
        int         k;
        logic       ra;
        ops = '{BEQ, JAL, JALR, LD, ST, OPR, OPI, LUI, AUIPC, 7'b1111111};
        tname = "random";
        push_idle(1'b1);
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 11);
            op = (k < 10) ? ops[k] : 7'($urandom);
            ra = (i == 39) ? 1'b0 : ($urandom_range(0, 5) != 0);
            add_instr(op, $urandom_range(0, 3), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 5), ra);
            if (!ra && i != 39) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) push_idle(1'b0);
                push_idle(1'b1);
            end
        end
        push_idle(1'b0);
        run_seg(-1);
    endtask

    task automatic test_async_reset();
        tname = "async_reset";
        push_idle(1'b1);
        add_instr(LD, 0, 0, 0, 10, 1'b0);
        // IDLE, FETCH, DECODE, DISPATCH, then three MEM cycles
        run_seg(7);
        @(posedge clk);
        #1;
        checks++;
        if (req3 !== 1'b1) begin
            errors++;
            $display("FAIL %s req3_before got=%b want=1", tname, req3);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (outs_now() !== outv_t'('0)) begin
            errors++;
            $display("FAIL %s outputs_after got=%b want=0", tname, outs_now());
        end
        checks++;
        if (retire_cnt !== '0) begin
            errors++;
            $display("FAIL %s cnt_after got=%0d want=0", tname, retire_cnt);
        end
        hold_reset_check();
        push_idle(1'b1);
        add_instr(AUIPC, 0, 0, 0, 0, 1'b0);
        push_idle(1'b0);
        run_seg(-1);
    endtask

    initial begin
        mcnt = '0;
        test_reset();
        test_alu();
        test_join();
        test_mem();
        test_branch();
        test_illegal_stop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
